// File: rtl/ex_div_unit_pkg.sv
// ex_div_unit_pkg: shared encodings for the EX-stage divider.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
// Contents: DIV_OP_* operation codes as driven on op_i, DIV_ST_* FSM states,
// and small decode helpers used by the divider datapath.
package ex_div_unit_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_CALC = 2'd1,
    DIV_ST_FIX  = 2'd2,
    DIV_ST_DONE = 2'd3
  } div_state_e;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/ex_div_unit_div_iter_step.sv
// div_iter_step: one radix-2 restoring division step.
// Latency: purely combinational.
// Backpressure: none.
// Ports: rem_i partial remainder, bit_i next dividend bit shifted in,
//        dsr_i divisor magnitude; rem_o new remainder, qbit_o quotient bit.
module div_iter_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] dsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic            qbit_o
);

  // The shifted remainder needs one extra bit: it can exceed 2^XLEN-1 before
  // the subtract, but the restored/subtracted result always fits in XLEN.
  logic [XLEN:0] trial;

  always_comb begin
    trial  = {rem_i, bit_i};
    qbit_o = (trial >= {1'b0, dsr_i});
    rem_o  = qbit_o ? (trial[XLEN-1:0] - dsr_i) : trial[XLEN-1:0];
  end

endmodule

// File: rtl/ex_div_unit.sv
// ex_div_unit: multi-cycle RV64M DIV/DIVU/REM/REMU (+W) restoring divider in EX.
// Latency: result_valid_o N+2 cycles after accept (N = 32 for W ops, else XLEN).
// Backpressure: holds stall_req_o from accept through FIX so the pipeline waits.
// Ports: clk, rst (sync, active-high); valid_i/op_i/word_i/dividend_i/divisor_i
//        request; flush_i abort; stall_req_o, result_valid_o, result_o, busy_o.
// Build option: DIV_FASTPATH_EN finishes divide-by-zero and signed overflow
//        in one cycle (IDLE -> DONE) instead of running all iterations.
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [1:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            stall_req_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN + 1);

  div_state_e      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            word_q, word_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;
  logic [XLEN-1:0] dvd_q, dvd_d;    // extended dividend, the div-by-zero remainder
  logic [XLEN-1:0] dsr_q, dsr_d;    // divisor magnitude
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;  // dividend bits shift out the top, quotient in
  logic [XLEN-1:0] result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            signed_op, sign_a, sign_b, in_dz;
  logic [XLEN-1:0] dvd_ext, dsr_ext, abs_a, abs_b;
  logic [XLEN-1:0] fix_q, fix_r, fix_res;
  logic [XLEN-1:0] step_rem;
  logic            step_qbit;

  function automatic logic [XLEN-1:0] pack_result(input logic [1:0] op, input logic word,
                                                  input logic [XLEN-1:0] q,
                                                  input logic [XLEN-1:0] r);
    logic [XLEN-1:0] sel;
    sel = is_rem_op(op) ? r : q;
    return word ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
  endfunction

  // Request-side operand conditioning (valid only while IDLE accepts).
  always_comb begin
    signed_op = is_signed_op(op_i);
    dvd_ext = dividend_i;
    dsr_ext = divisor_i;
    if (word_i) begin
      dvd_ext = {{(XLEN-32){signed_op & dividend_i[31]}}, dividend_i[31:0]};
      dsr_ext = {{(XLEN-32){signed_op & divisor_i[31]}}, divisor_i[31:0]};
    end
    sign_a = signed_op & dvd_ext[XLEN-1];
    sign_b = signed_op & dsr_ext[XLEN-1];
    abs_a  = sign_a ? -dvd_ext : dvd_ext;
    abs_b  = sign_b ? -dsr_ext : dsr_ext;
    in_dz  = (dsr_ext == '0);
  end

`ifdef DIV_FASTPATH_EN
  logic            in_ovf;
  logic [XLEN-1:0] fast_res;
  always_comb begin
    in_ovf = signed_op & (dsr_ext == '1) &
             (dvd_ext == (word_i ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}}));
    fast_res = pack_result(op_i, word_i, in_dz ? '1 : dvd_ext, in_dz ? dvd_ext : '0);
  end
`endif

  div_iter_step #(.XLEN(XLEN)) u_step (
    .rem_i  (rem_q),
    .bit_i  (quot_q[XLEN-1]),
    .dsr_i  (dsr_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  // Signed overflow needs no special case here: |most-negative| / 1 already
  // yields the most-negative pattern with a positive quotient sign.
  always_comb begin
    fix_q   = dz_q ? '1 : (qneg_q ? -quot_q : quot_q);
    fix_r   = dz_q ? dvd_q : (rneg_q ? -rem_q : rem_q);
    fix_res = pack_result(op_q, word_q, fix_q, fix_r);
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    word_d      = word_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dz_d        = dz_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    stall_req_o = 1'b0;
    case (state_q)
      DIV_ST_IDLE: begin
        if (valid_i && !flush_i) begin
          stall_req_o = 1'b1;
          op_d    = op_i;
          word_d  = word_i;
          qneg_d  = sign_a ^ sign_b;
          rneg_d  = sign_a;
          dz_d    = in_dz;
          dvd_d   = dvd_ext;
          dsr_d   = abs_b;
          rem_d   = '0;
          // W ops start with the 32-bit magnitude in the top half so the
          // shift-out bit is always quot_q[XLEN-1].
          quot_d  = word_i ? (abs_a << 32) : abs_a;
          cnt_d   = word_i ? CW'(32) : CW'(XLEN);
          state_d = DIV_ST_CALC;
`ifdef DIV_FASTPATH_EN
          if (in_dz || in_ovf) begin
            result_d = fast_res;
            state_d  = DIV_ST_DONE;
          end
`endif
        end
      end
      DIV_ST_CALC: begin
        if (flush_i) begin
          state_d = DIV_ST_IDLE;
        end else begin
          stall_req_o = 1'b1;
          rem_d  = step_rem;
          quot_d = {quot_q[XLEN-2:0], step_qbit};
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = DIV_ST_FIX;
        end
      end
      DIV_ST_FIX: begin
        if (flush_i) begin
          state_d = DIV_ST_IDLE;
        end else begin
          stall_req_o = 1'b1;
          result_d = fix_res;
          state_d  = DIV_ST_DONE;
        end
      end
      default: begin
        // DONE: the same instruction is still in EX, so valid_i is ignored.
        state_d = DIV_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_ST_IDLE;
      op_q     <= '0;
      word_q   <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result_valid_o = (state_q == DIV_ST_DONE);
  assign busy_o         = (state_q != DIV_ST_IDLE);
  assign result_o       = result_q;

endmodule

// File: tb/tb_ex_div_unit.sv
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [1:0]  op_i;
  logic        word_i;
  logic [63:0] dividend_i;
  logic [63:0] divisor_i;
  logic        flush_i;
  logic        stall_req_o;
  logic        result_valid_o;
  logic [63:0] result_o;
  logic        busy_o;

  ex_div_unit #(.XLEN(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .op_i           (op_i),
    .word_i         (word_i),
    .dividend_i     (dividend_i),
    .divisor_i      (divisor_i),
    .flush_i        (flush_i),
    .stall_req_o    (stall_req_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
`ifdef DIV_FASTPATH_EN
  localparam int SPC64 = 1;   // special-case latency / stall cycles, 64-bit
  localparam int SPC32 = 1;
`else
  localparam int SPC64 = 66;
  localparam int SPC32 = 34;
`endif

  typedef struct {
    logic [63:0] res;
    int          issue;
    int          lat;
    int          stall;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   stall_cnt = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", n, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each result_valid_o.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (stall_req_o) stall_cnt++;
      if (result_valid_o) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result_valid got=%h expected=none", result_o);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_result"}, result_o, e.res);
          chk({e.name, "_latency"}, 64'(cyc - e.issue), 64'(e.lat));
          chk({e.name, "_stall_cycles"}, 64'(stall_cnt), 64'(e.stall));
        end
      end
    end
  end

  task automatic issue(input string n, input logic [1:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] res, input int lat, input int st, input bit push);
    exp_t e;
    @(posedge clk); #1;
    valid_i = 1'b1; op_i = op; word_i = w; dividend_i = a; divisor_i = b;
    stall_cnt = 0;
    if (push) begin
      e.res = res; e.issue = cyc; e.lat = lat; e.stall = st; e.name = n;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_done(input string n);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy_o) return;
    end
    checks++;
    failures++;
    $display("FAIL %s_timeout got=pending expected=done", n);
    sb.delete();
  endtask

  task automatic run(input string n, input logic [1:0] op, input logic w,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] res, input int lat, input int st);
    issue(n, op, w, a, b, res, lat, st, 1'b1);
    wait_done(n);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; op_i = '0; word_i = 1'b0;
    dividend_i = '0; divisor_i = '0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", 64'(stall_req_o), 64'd0);
    chk("reset_valid", 64'(result_valid_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run("divu_100_7", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66, 66);
    run("div_m7_2",   OP_DIV,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 66);
    run("rem_m7_2",   OP_REM,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 66);
    run("remu_7_2",   OP_REMU, 1'b0, 64'd7, 64'd2, 64'd1, 66, 66);
    run("div_5_0",    OP_DIV,  1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, SPC64, SPC64);
    run("rem_m5_0",   OP_REM,  1'b0, -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, SPC64, SPC64);
    run("div_ovf",    OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0000, SPC64, SPC64);
    run("rem_ovf",    OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'd0, SPC64, SPC64);
    run("divw_ovf",   OP_DIV,  1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'hFFFF_FFFF_8000_0000, SPC32, SPC32);
    run("divuw",      OP_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 34, 34);
    run("remw_m7_2",  OP_REM,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, 34);
    run("remuw",      OP_REMU, 1'b1, 64'h0000_0001_0000_0007, 64'h0000_0005_0000_0002, 64'd1, 34, 34);

    // Flush in the 10th CALC cycle: op must vanish with no result.
    issue("flushed", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd0, 0, 0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_stall_same_cycle", 64'(stall_req_o), 64'd0);
    chk("flush_busy_before", 64'(busy_o), 64'd1);
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_busy_after", 64'(busy_o), 64'd0);
    chk("flush_no_valid", 64'(result_valid_o), 64'd0);
    run("divu_9_3_after_flush", OP_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 66, 66);

    // Reset in the middle of CALC clears everything.
    issue("reset_mid", OP_DIV, 1'b0, 64'd1000, 64'd10, 64'd0, 0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_stall", 64'(stall_req_o), 64'd0);
    chk("rst_mid_valid", 64'(result_valid_o), 64'd0);
    chk("rst_mid_result", result_o, 64'd0);
    chk("rst_mid_busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run("divu_after_rst", OP_DIVU, 1'b0, 64'd1000, 64'd10, 64'd100, 66, 66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
Multi-cycle RV64M divider in the EX stage. It executes DIV/DIVU/REM/REMU and their W variants using radix-2 restoring iteration. It drives the mul/div stall request into the pipeline hazard controller, which holds PC/Pre_IF/IF_ID and flushes EX_MEM while the request is high. It consumes that controller's EX-stage flush bit to abort.

Parameters:
XLEN, 64, datapath width; W ops use the low 32 bits.

Ports:
clk  input  1  clock
rst  input  1  reset: rst, synchronous, active-high
valid_i  input  1  divide op present in EX
op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
word_i  input  1  W variant (32-bit operands, sign-extended result)
dividend_i  input  XLEN  rs1 value
divisor_i  input  XLEN  rs2 value
flush_i  input  1  abort current op (EX flush from hazard controller)
stall_req_o  output  1  to controller alu_mul_div_valid_ex_i
result_valid_o  output  1  result_o valid this cycle
result_o  output  XLEN  quotient or remainder
busy_o  output  1  FSM not IDLE

Behaviour:
- Reset (also mid-operation): state=IDLE; result_valid_o=0, result_o=0, busy_o=0; internal registers cleared. stall_req_o is then 0 unless valid_i is high.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If valid_i & ~flush_i: latch op, word, and operands (W: low 32 bits; sign-extended for signed ops, zero-extended for unsigned ops).
  - Take the absolute values for signed ops. Record the quotient sign (sa^sb) and the remainder sign (sa).
  - Set the iteration counter N = 32 (word) or XLEN. Go to CALC.
- CALC: one quotient bit per cycle, shifting the {rem,quot} register. The counter decrements, and CALC goes to FIX when the count reaches 1.
- FIX:
  - Apply negation per the recorded signs.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU).
  - W ops: sign-extend bit 31 to XLEN.
  - Register into result_o. Go to DONE.
- DONE: result_valid_o=1 for exactly one cycle; next state is IDLE. valid_i is ignored in DONE, because the same instruction is still in EX.
- stall_req_o is combinational: (IDLE & valid_i & ~flush_i) | CALC | FIX. It is 0 in DONE, so the pipeline advances on the result cycle.
- Latency: accept at cycle 0; result_valid at cycle N+2; stall_req_o high for N+2 cycles.
- Divide by zero: quotient = all ones, remainder = dividend. Sign fixup is suppressed.
- Signed overflow (most-negative / -1, at XLEN or 32-bit width): quotient = dividend, remainder = 0.
- flush_i in CALC/FIX: next state is IDLE. No result_valid, stall_req_o drops the same cycle.
- flush_i in DONE: result_valid_o is still asserted; the controller discards it.
- Simultaneous flush_i & valid_i in IDLE: not accepted.
- result_o holds its last value outside DONE.

Optional Feature:
- DIV_FASTPATH_EN defined: zero-divisor and signed-overflow cases skip CALC/FIX. IDLE goes to DONE directly with the result registered. stall_req_o is high for 1 cycle and result_valid is asserted at cycle 1.
- Undefined: these cases run the full N iterations. The results are identical; only latency differs.

Decomposition:
- Shared header (alongside sysconfig.v): op encodings DIV_OP_DIV/DIVU/REM/REMU and FSM state encodings DIV_ST_*.
- Sub-module div_iter_step: purely combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder and quotient bit.
  - Instantiated once.

Test Plan:
- DIVU 100/7, word=0 -> result 14; stall_req_o high cycles 0..65; result_valid at cycle 66 for one cycle.
- DIV -7/2 -> 0xFFFFFFFFFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFFFFFFFFFF (-1); REMU 7/2 -> 1.
- DIV 5/0 -> 0xFFFFFFFFFFFFFFFF; REM -5/0 -> 0xFFFFFFFFFFFFFFFB. With DIV_FASTPATH_EN, stall lasts 1 cycle and result at cycle 1; without it, result at cycle 66.
- DIV 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF -> 0x8000000000000000; REM -> 0.
- DIVW dividend 0x0000000180000000, divisor 0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFF80000000. DIVUW 0xFFFFFFFFFFFFFFFE / 2 -> 0x000000007FFFFFFF; stall high 34 cycles.
- flush_i in CALC cycle 10 -> IDLE next cycle; stall_req_o low and no result_valid. A new DIVU 9/3 the following cycle -> 3. Reset asserted mid-CALC -> all outputs 0 next cycle.
